// File: rtl/seven_seg_scanner_if.sv
// Display bus for seven_seg_scanner: BCD/dp/control in, multiplexed drive out.
// blink_mask exists only when SEG_BLINK_EN is defined.
interface seven_seg_scanner_if;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        blank_lz;
  logic [1:0]  digit_sel;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp_n;
`ifdef SEG_BLINK_EN
  logic [3:0]  blink_mask;

  modport master (output en, digits, dp, blank_lz, blink_mask,
                  input  digit_sel, anode, seg, dp_n);
  modport slave  (input  en, digits, dp, blank_lz, blink_mask,
                  output digit_sel, anode, seg, dp_n);
`else
  modport master (output en, digits, dp, blank_lz,
                  input  digit_sel, anode, seg, dp_n);
  modport slave  (input  en, digits, dp, blank_lz,
                  output digit_sel, anode, seg, dp_n);
`endif
endinterface

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed 7-segment scanner with leading-zero blanking.
// Optional blink feature compiled in with `define SEG_BLINK_EN.
module seven_seg_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                clk,
  input  logic                reset,
  seven_seg_scanner_if.slave  disp
);
  localparam int PW = $clog2(REFRESH_DIV);

  logic [PW-1:0] presc, presc_nxt;
  logic [1:0]    sel, sel_nxt;
  logic          tick;
  logic [3:0]    nib;
  logic          z3, z2, z1;
  logic [3:0]    blank_vec, blink_vec;

  function automatic logic [6:0] bcd2seg(input logic [3:0] v);
    case (v)
      4'd0: bcd2seg = 7'h40;
      4'd1: bcd2seg = 7'h79;
      4'd2: bcd2seg = 7'h24;
      4'd3: bcd2seg = 7'h30;
      4'd4: bcd2seg = 7'h19;
      4'd5: bcd2seg = 7'h12;
      4'd6: bcd2seg = 7'h02;
      4'd7: bcd2seg = 7'h78;
      4'd8: bcd2seg = 7'h00;
      4'd9: bcd2seg = 7'h10;
      default: bcd2seg = 7'h7F;
    endcase
  endfunction

  always_comb begin
    tick      = disp.en && (presc == PW'(REFRESH_DIV - 1));
    presc_nxt = presc;
    if (tick)         presc_nxt = '0;
    else if (disp.en) presc_nxt = presc + PW'(1);
    sel_nxt   = tick ? sel + 2'd1 : sel;
    // Outputs are built from the digit that will be selected after this edge
    nib       = disp.digits[{sel_nxt, 2'b00} +: 4];
    z3        = (disp.digits[15:12] == 4'd0);
    z2        = z3 && (disp.digits[11:8] == 4'd0);
    z1        = z2 && (disp.digits[7:4] == 4'd0);
    blank_vec = ({z3, z2, z1, 1'b0} & {4{disp.blank_lz}}) | blink_vec;
  end

`ifdef SEG_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FW-1:0] frame;
  logic          phase;

  // One frame = one full 3->0 wrap of the digit scan
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame <= '0;
      phase <= 1'b0;
    end else if (tick && sel == 2'd3) begin
      if (frame == FW'(BLINK_FRAMES - 1)) begin
        frame <= '0;
        phase <= ~phase;
      end else begin
        frame <= frame + FW'(1);
      end
    end
  end

  assign blink_vec = phase ? disp.blink_mask : 4'h0;
`else
  // BLINK_FRAMES is inert in this build; the expression is constant zero
  assign blink_vec = (BLINK_FRAMES < 0) ? 4'hF : 4'h0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc     <= '0;
      sel       <= 2'd0;
      disp.anode <= 4'hF;
      disp.seg   <= 7'h7F;
      disp.dp_n  <= 1'b1;
    end else begin
      presc <= presc_nxt;
      sel   <= sel_nxt;
      if (!disp.en || blank_vec[sel_nxt]) begin
        disp.anode <= 4'hF;
        disp.seg   <= 7'h7F;
        disp.dp_n  <= 1'b1;
      end else begin
        // The cycle after a tick is dead time so adjacent digits never overlap
        disp.anode <= tick ? 4'hF : ~(4'b0001 << sel_nxt);
        disp.seg   <= bcd2seg(nib);
        disp.dp_n  <= ~disp.dp[sel_nxt];
      end
    end
  end

  assign disp.digit_sel = sel;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed self-checking bench for seven_seg_scanner (REFRESH_DIV=4, BLINK_FRAMES=2).
module tb_seven_seg_scanner;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  seven_seg_scanner_if ifc();

  seven_seg_scanner #(.REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .disp  (ifc)
  );

  logic [3:0] an_tab [4]  = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_reset;
    ifc.en = 1'b1; ifc.digits = 16'h1234; ifc.dp = 4'h0; ifc.blank_lz = 1'b0;
    step; step;
    n_cmp++; if (ifc.anode !== 4'hF) begin n_bad++; $display("FAIL reset_anode got %h want F", ifc.anode); end
    n_cmp++; if (ifc.seg !== 7'h7F) begin n_bad++; $display("FAIL reset_seg got %h want 7F", ifc.seg); end
    n_cmp++; if (ifc.dp_n !== 1'b1) begin n_bad++; $display("FAIL reset_dp_n got %b want 1", ifc.dp_n); end
    n_cmp++; if (ifc.digit_sel !== 2'd0) begin n_bad++; $display("FAIL reset_sel got %0d want 0", ifc.digit_sel); end
    @(negedge clk); reset = 1'b1;
    step;
    n_cmp++; if (ifc.anode !== 4'hE || ifc.seg !== 7'h19) begin n_bad++;
      $display("FAIL first_lit got anode=%h seg=%h want E/19", ifc.anode, ifc.seg); end
    repeat (5) step;
    n_cmp++; if (ifc.anode !== 4'hD) begin n_bad++; $display("FAIL midslot_pre got %h want D", ifc.anode); end
    reset = 1'b0; #1;
    n_cmp++; if (ifc.anode !== 4'hF || ifc.seg !== 7'h7F || ifc.dp_n !== 1'b1 || ifc.digit_sel !== 2'd0) begin n_bad++;
      $display("FAIL async_reset got anode=%h seg=%h dp_n=%b sel=%0d want F/7F/1/0",
               ifc.anode, ifc.seg, ifc.dp_n, ifc.digit_sel); end
    @(negedge clk); reset = 1'b1;
    step;
    n_cmp++; if (ifc.anode !== 4'hE || ifc.digit_sel !== 2'd0) begin n_bad++;
      $display("FAIL post_reset got anode=%h sel=%0d want E/0", ifc.anode, ifc.digit_sel); end
  endtask

  task automatic test_scan;
    logic [6:0] exp_seg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    ifc.en = 1'b1; ifc.digits = 16'h1234; ifc.dp = 4'h0; ifc.blank_lz = 1'b0;
    apply_reset;
    for (int n = 0; n < 20; n++) begin
      int s;
      s = (n / 4) % 4;
      step;
      if (n % 4 == 3) begin
        n_cmp++; if (ifc.anode !== 4'hF) begin n_bad++; $display("FAIL scan_dead n=%0d got %h want F", n, ifc.anode); end
      end else begin
        n_cmp++; if (ifc.anode !== an_tab[s] || ifc.seg !== exp_seg[s] || ifc.dp_n !== 1'b1) begin n_bad++;
          $display("FAIL scan_lit n=%0d got %h/%h/%b want %h/%h/1", n, ifc.anode, ifc.seg, ifc.dp_n, an_tab[s], exp_seg[s]); end
      end
      n_cmp++; if (ifc.digit_sel !== 2'((n + 1) / 4)) begin n_bad++;
        $display("FAIL scan_sel n=%0d got %0d want %0d", n, ifc.digit_sel, ((n + 1) / 4) % 4); end
    end
  endtask

  task automatic test_decoder;
    ifc.en = 1'b1; ifc.dp = 4'h0; ifc.blank_lz = 1'b0;
    for (int v = 0; v < 16; v++) begin
      ifc.digits = {4{4'(v)}};
      apply_reset;
      step;
      n_cmp++; if (ifc.anode !== 4'hE || ifc.seg !== dec_tab[v]) begin n_bad++;
        $display("FAIL decode v=%0d got %h/%h want E/%h", v, ifc.anode, ifc.seg, dec_tab[v]); end
    end
  endtask

  task automatic test_blank_lz;
    logic [15:0] vd [3]    = '{16'h0050, 16'h0000, 16'h0105};
    logic [3:0]  ea [3][4] = '{'{4'hE, 4'hD, 4'hF, 4'hF}, '{4'hE, 4'hF, 4'hF, 4'hF}, '{4'hE, 4'hD, 4'hB, 4'hF}};
    logic [6:0]  es [3][4] = '{'{7'h40, 7'h12, 7'h7F, 7'h7F}, '{7'h40, 7'h7F, 7'h7F, 7'h7F},
                               '{7'h12, 7'h40, 7'h79, 7'h7F}};
    logic        ed [3][4] = '{'{1'b0, 1'b0, 1'b1, 1'b1}, '{1'b0, 1'b1, 1'b1, 1'b1}, '{1'b0, 1'b0, 1'b0, 1'b1}};
    ifc.en = 1'b1; ifc.dp = 4'hF; ifc.blank_lz = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ifc.digits = vd[k];
      apply_reset;
      for (int n = 0; n < 16; n++) begin
        int s;
        s = n / 4;
        step;
        if (n % 4 == 3) begin
          n_cmp++; if (ifc.anode !== 4'hF) begin n_bad++; $display("FAIL blz_dead k=%0d n=%0d got %h", k, n, ifc.anode); end
        end else begin
          n_cmp++; if (ifc.anode !== ea[k][s] || ifc.seg !== es[k][s] || ifc.dp_n !== ed[k][s]) begin n_bad++;
            $display("FAIL blz k=%0d n=%0d got %h/%h/%b want %h/%h/%b", k, n, ifc.anode, ifc.seg, ifc.dp_n,
                     ea[k][s], es[k][s], ed[k][s]); end
        end
      end
    end
    ifc.dp = 4'h0; ifc.blank_lz = 1'b0;
  endtask

  task automatic test_enable;
    logic [3:0] ra [4] = '{4'hD, 4'hD, 4'hF, 4'hB};
    logic [1:0] rs [4] = '{2'd1, 2'd1, 2'd2, 2'd2};
    ifc.en = 1'b1; ifc.digits = 16'h1234; ifc.dp = 4'h0; ifc.blank_lz = 1'b0;
    apply_reset;
    repeat (5) step;
    ifc.en = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step;
      n_cmp++; if (ifc.anode !== 4'hF || ifc.seg !== 7'h7F || ifc.dp_n !== 1'b1 || ifc.digit_sel !== 2'd1) begin n_bad++;
        $display("FAIL en_off n=%0d got %h/%h/%b sel=%0d want F/7F/1 sel=1", n, ifc.anode, ifc.seg, ifc.dp_n, ifc.digit_sel); end
    end
    ifc.en = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step;
      n_cmp++; if (ifc.anode !== ra[n] || ifc.digit_sel !== rs[n]) begin n_bad++;
        $display("FAIL en_resume n=%0d got %h sel=%0d want %h sel=%0d", n, ifc.anode, ifc.digit_sel, ra[n], rs[n]); end
    end
    n_cmp++; if (ifc.seg !== 7'h24) begin n_bad++; $display("FAIL en_resume_seg got %h want 24", ifc.seg); end
  endtask

  task automatic test_live_update;
    ifc.en = 1'b1; ifc.digits = 16'h1234; ifc.dp = 4'h0; ifc.blank_lz = 1'b0;
    apply_reset;
    step;
    n_cmp++; if (ifc.seg !== 7'h19 || ifc.dp_n !== 1'b1) begin n_bad++;
      $display("FAIL live0 got %h/%b want 19/1", ifc.seg, ifc.dp_n); end
    ifc.digits = 16'h1239; ifc.dp = 4'b0001;
    step;
    n_cmp++; if (ifc.seg !== 7'h10 || ifc.dp_n !== 1'b0 || ifc.anode !== 4'hE) begin n_bad++;
      $display("FAIL live1 got %h/%h/%b want E/10/0", ifc.anode, ifc.seg, ifc.dp_n); end
    ifc.digits = 16'h123C;
    step;
    n_cmp++; if (ifc.seg !== 7'h7F || ifc.anode !== 4'hE) begin n_bad++;
      $display("FAIL bad_bcd got %h/%h want E/7F", ifc.anode, ifc.seg); end
    ifc.dp = 4'h0;
  endtask

`ifdef SEG_BLINK_EN
  task automatic test_blink;
    ifc.en = 1'b1; ifc.digits = 16'h1234; ifc.dp = 4'h0; ifc.blank_lz = 1'b0; ifc.blink_mask = 4'b0001;
    apply_reset;
    for (int n = 0; n < 96; n++) begin
      int f, s;
      logic [3:0] ea;
      f = n / 16; s = (n % 16) / 4;
      ea = (n % 4 == 3) ? 4'hF : ((s == 0 && (f / 2) % 2 == 1) ? 4'hF : an_tab[s]);
      step;
      n_cmp++; if (ifc.anode !== ea) begin n_bad++;
        $display("FAIL blink n=%0d got %h want %h", n, ifc.anode, ea); end
    end
    ifc.blink_mask = 4'h0;
  endtask
`endif

  initial begin
    ifc.en = 1'b0; ifc.digits = 16'h0; ifc.dp = 4'h0; ifc.blank_lz = 1'b0;
`ifdef SEG_BLINK_EN
    ifc.blink_mask = 4'h0;
`endif
    test_reset;
    test_scan;
    test_decoder;
    test_blank_lz;
    test_enable;
    test_live_update;
`ifdef SEG_BLINK_EN
    test_blink;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  REFRESH_DIV  100000  clk cycles per digit slot, legal range 2..2^20
  BLINK_FRAMES  64  full 4-digit scans per blink half-period (used only with SEG_BLINK_EN)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single system clock
  reset  in  1  asynchronous, active-low reset
  en  in  1  scan enable
  digits  in  16  four BCD digits; [3:0]=digit0 (rightmost) ... [15:12]=digit3
  dp  in  4  decimal-point request per digit, active-high
  blank_lz  in  1  leading-zero blanking enable
  digit_sel  out  2  index of the digit currently being scanned
  anode  out  4  digit enables, active-low; anode[i] drives digit i
  seg  out  7  segments, active-low; seg[0]=a ... seg[6]=g
  dp_n  out  1  decimal point, active-low
  blink_mask  in  4  per-digit blink request (present only with SEG_BLINK_EN)

Function
REQ-003 The prescaler SHALL count 0..REFRESH_DIV-1 while en=1 and SHALL hold its value while en=0.
REQ-004 A tick SHALL occur when the prescaler equals REFRESH_DIV-1 and en=1; on a tick the prescaler SHALL go to 0 and digit_sel SHALL advance modulo 4 (0,1,2,3,0).
REQ-005 anode, seg and dp_n SHALL be registered outputs, computed from the post-update digit_sel, with one clk of latency.
REQ-006 In the cycle following a tick, anode SHALL be 4'hF (dead time), so each digit is lit for REFRESH_DIV-1 cycles per slot.
REQ-007 Outside dead time with en=1, anode SHALL be the one-cold code of digit_sel (E, D, B, 7 for digits 0..3), unless that digit is blanked.
REQ-008 The decoder SHALL map BCD values to seg as follows: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex); values 10-15 SHALL give 7F while the anode stays asserted.
REQ-009 With blank_lz=1, leading-zero blanking SHALL apply:
  digit3 is blanked if it is 0
  digit2 is blanked if digit3 and digit2 are both 0
  digit1 is blanked if digit3, digit2 and digit1 are all 0
  digit0 is never blanked
REQ-010 A blanked digit SHALL drive anode=4'hF, seg=7'h7F and dp_n=1.
REQ-011 dp_n SHALL be ~dp[digit_sel] for an active, unblanked digit.
REQ-012 While en=0, the outputs SHALL be anode=4'hF, seg=7'h7F and dp_n=1 from the next clk, and digit_sel SHALL hold.
REQ-013 When en returns to 1, scanning SHALL resume at the held digit_sel and prescaler value.
REQ-014 digits, dp and blank_lz SHALL be sampled every clk; a mid-slot change SHALL appear on seg one clk later.

Reset
REQ-015 Asserting reset (low) SHALL immediately set: prescaler=0, digit_sel=0, anode=4'hF, seg=7'h7F, dp_n=1, frame counter=0, blink phase=0.
REQ-016 Reset asserted mid-slot SHALL abort the slot; after release, the first lit digit SHALL be digit0, lit starting the clk after release.

Configuration
REQ-017 The macro SEG_BLINK_EN SHALL compile in the blink feature.
REQ-018 When SEG_BLINK_EN is defined:
  the blink_mask port exists
  a frame counter increments on each digit_sel 3->0 wrap
  blink phase toggles every BLINK_FRAMES frames
  while blink phase=1, every digit with blink_mask[i]=1 is blanked per REQ-010
REQ-019 When SEG_BLINK_EN is undefined, the block SHALL have no blink_mask port, no frame counter and no blinking, and BLINK_FRAMES SHALL have no effect.

Verification (REFRESH_DIV=4 unless stated)
REQ-020 Scan order: digits=16'h1234, dp=0, blank_lz=0, en=1 -> per slot, 1 dead cycle then 3 lit cycles, in this sequence:
  anode=E with seg=19
  anode=D with seg=30
  anode=B with seg=24
  anode=7 with seg=79
  wrapping back to anode=E
REQ-021 Leading-zero blanking: digits=16'h0050, blank_lz=1 -> only anode E (seg=40) and anode D (seg=12) are ever asserted; in the digit2 and digit3 slots anode=F.
REQ-022 Enable gating: en=0 for 10 cycles in the middle of the digit1 slot -> anode=F and digit_sel=1 throughout; on en=1, digit1 relights and the remaining prescaler count completes before the tick.
REQ-023 Reset mid-slot and invalid BCD:
  reset low mid-slot -> anode=F, seg=7F, dp_n=1 with no clock edge needed
  digits[3:0]=4'hC -> seg=7F with anode=E during the lit digit0 cycles
REQ-024 With SEG_BLINK_EN, BLINK_FRAMES=2, blink_mask=4'b0001 -> digit0 is lit for 2 frames, then dark (anode=F in its slot) for 2 frames, repeating; digits 1-3 are unaffected.
